// File: rtl/mem_stage_pkg.sv
// PipelineReg: EX->MEM and MEM->WB pipeline register layouts, memory access
// type codes and the MEM stage FSM encoding shared by the RV32 core.
package PipelineReg;

   localparam logic [3:0] MT_B  = 4'b0001;
   localparam logic [3:0] MT_H  = 4'b0011;
   localparam logic [3:0] MT_W  = 4'b1111;
   localparam logic [3:0] MT_BU = 4'b1000;
   localparam logic [3:0] MT_HU = 4'b1100;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ALUOutput;
      logic [31:0] write_reg;
      logic [3:0]  mem_type;
      logic        MemRead;
      logic        MemWrite;
      logic        MemToReg;
      logic        RegWrite;
      logic [4:0]  rd;
   } MEM_STATE;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ALUOutput;
      logic [31:0] MemData;
      logic        MemToReg;
      logic        RegWrite;
      logic [4:0]  rd;
   } WB_STATE;

   typedef enum logic {IDLE, BUSY} mem_fsm_t;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} acc_size_t;

   // Unknown codes (including 0000) fall back to a full word access.
   function automatic acc_size_t mt_size(input logic [3:0] mt);
      case (mt)
         MT_B, MT_BU: return SZ_B;
         MT_H, MT_HU: return SZ_H;
         default:     return SZ_W;
      endcase
   endfunction

   function automatic logic mt_signed(input logic [3:0] mt);
      return (mt == MT_B) || (mt == MT_H);
   endfunction

endpackage

// File: rtl/mem_stage_align.sv
// mem_align: byte-lane logic for data-memory accesses -- byte enables,
// store-data replication and load extraction with sign/zero extension.
module mem_align
   import PipelineReg::*;
(
   input  logic [3:0]  mem_type,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic        sext;
   logic [31:0] w;

   always_comb begin
      // NOTE: every variable gets a default first so no latch is inferred.
      sext      = mt_signed(mem_type);
      w         = rdata >> {addr_lo, 3'b000};
      be        = 4'b1111 << addr_lo;
      wdata     = store_data;
      load_data = w;
      // Shifting a 4-bit mask drops lanes past byte 3 (misaligned truncation).
      case (mt_size(mem_type))
         SZ_B: begin
            be        = 4'b0001 << addr_lo;
            wdata     = {4{store_data[7:0]}};
            load_data = {{24{sext & w[7]}}, w[7:0]};
         end
         SZ_H: begin
            be        = 4'b0011 << addr_lo;
            wdata     = {2{store_data[15:0]}};
            load_data = {{16{sext & w[15]}}, w[15:0]};
         end
         default: begin
            be        = 4'b1111 << addr_lo;
            wdata     = store_data;
            load_data = w;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32 MEM pipeline stage; runs the data-memory req/ack access and
// registers the MEM->WB state. Optional MEM_MISALIGN_CHECK_EN blocks misaligned accesses.
module mem_stage
   import PipelineReg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  MEM_STATE          i_mem_state,
   output WB_STATE           o_wb_state,
   output logic              o_stall,
   output logic              o_dmem_req,
   output logic              o_dmem_we,
   output logic [ADDR_W-1:0] o_dmem_addr,
   output logic [DATA_W-1:0] o_dmem_wdata,
   output logic [3:0]        o_dmem_be,
   input  logic              i_dmem_ack,
   input  logic [DATA_W-1:0] i_dmem_rdata
`ifdef MEM_MISALIGN_CHECK_EN
   ,
   output logic              o_misalign
`endif
);

   mem_fsm_t    state;
   logic [3:0]  lat_mem_type;
   logic [1:0]  lat_addr_lo;
   logic [31:0] lat_pc;
   logic [31:0] lat_alu;
   logic        lat_mem_to_reg;
   logic        lat_reg_write;
   logic [4:0]  lat_rd;

   logic        is_mem;
   logic        misaligned;
   logic        issue;
   logic [3:0]  align_type;
   logic [1:0]  align_lo;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic [31:0] load_c;

   assign is_mem = i_mem_state.MemRead | i_mem_state.MemWrite;

`ifdef MEM_MISALIGN_CHECK_EN
   always_comb begin
      misaligned = 1'b0;
      case (mt_size(i_mem_state.mem_type))
         SZ_H:    misaligned = i_mem_state.ALUOutput[0];
         SZ_W:    misaligned = |i_mem_state.ALUOutput[1:0];
         default: misaligned = 1'b0;
      endcase
   end
`else
   assign misaligned = 1'b0;
`endif

   assign issue = is_mem & ~misaligned;

   // While busy the extractor works from the latched access, not the live input.
   assign align_type = (state == BUSY) ? lat_mem_type : i_mem_state.mem_type;
   assign align_lo   = (state == BUSY) ? lat_addr_lo  : i_mem_state.ALUOutput[1:0];

   mem_align u_align (
      .mem_type   (align_type),
      .addr_lo    (align_lo),
      .store_data (i_mem_state.write_reg),
      .rdata      (i_dmem_rdata),
      .be         (be_c),
      .wdata      (wdata_c),
      .load_data  (load_c)
   );

   assign o_stall = ~i_reset & (((state == IDLE) & issue) | ((state == BUSY) & ~i_dmem_ack));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state          <= IDLE;
         o_dmem_req     <= 1'b0;
         o_dmem_we      <= 1'b0;
         o_dmem_addr    <= '0;
         o_dmem_wdata   <= '0;
         o_dmem_be      <= '0;
         o_wb_state     <= '0;
         lat_mem_type   <= '0;
         lat_addr_lo    <= '0;
         lat_pc         <= '0;
         lat_alu        <= '0;
         lat_mem_to_reg <= 1'b0;
         lat_reg_write  <= 1'b0;
         lat_rd         <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
         o_misalign     <= 1'b0;
`endif
      end else begin
`ifdef MEM_MISALIGN_CHECK_EN
         o_misalign <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (issue) begin
                  state          <= BUSY;
                  o_dmem_req     <= 1'b1;
                  o_dmem_we      <= i_mem_state.MemWrite;
                  o_dmem_addr    <= {i_mem_state.ALUOutput[ADDR_W-1:2], 2'b00};
                  o_dmem_wdata   <= wdata_c;
                  o_dmem_be      <= be_c;
                  lat_mem_type   <= i_mem_state.mem_type;
                  lat_addr_lo    <= i_mem_state.ALUOutput[1:0];
                  lat_pc         <= i_mem_state.pc;
                  lat_alu        <= i_mem_state.ALUOutput;
                  lat_mem_to_reg <= i_mem_state.MemToReg;
                  lat_reg_write  <= i_mem_state.RegWrite;
                  lat_rd         <= i_mem_state.rd;
                  o_wb_state     <= '0;
               end else begin
                  o_wb_state.pc        <= i_mem_state.pc;
                  o_wb_state.ALUOutput <= i_mem_state.ALUOutput;
                  o_wb_state.MemData   <= '0;
                  o_wb_state.MemToReg  <= i_mem_state.MemToReg & ~(is_mem & misaligned);
                  o_wb_state.RegWrite  <= i_mem_state.RegWrite & ~(is_mem & misaligned);
                  o_wb_state.rd        <= i_mem_state.rd;
`ifdef MEM_MISALIGN_CHECK_EN
                  o_misalign           <= is_mem & misaligned;
`endif
               end
            end
            BUSY: begin
               if (i_dmem_ack) begin
                  state                <= IDLE;
                  o_dmem_req           <= 1'b0;
                  o_dmem_we            <= 1'b0;
                  o_dmem_addr          <= '0;
                  o_dmem_wdata         <= '0;
                  o_dmem_be            <= '0;
                  o_wb_state.pc        <= lat_pc;
                  o_wb_state.ALUOutput <= lat_alu;
                  o_wb_state.MemData   <= o_dmem_we ? 32'h0 : load_c;
                  o_wb_state.MemToReg  <= lat_mem_to_reg;
                  o_wb_state.RegWrite  <= lat_reg_write;
                  o_wb_state.rd        <= lat_rd;
               end
            end
         endcase
      end
   end

endmodule
